// File: rtl/sipo_symbol_collector.sv
// sipo_symbol_collector
//   Collects SIZE_DATA_OUT/SIZE_DATA_IN serial symbols into one word and
//   presents it on a valid/ready output register that is separate from the
//   shift register, so collection carries on while a word waits.
//   Build option: define SIPO_LSB_FIRST_EN to place the first symbol of a
//   word in the least-significant slot (default is MSB-first).
module sipo_symbol_collector #(
    parameter int SIZE_DATA_IN  = 2,
    parameter int SIZE_DATA_OUT = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_start,
    input  logic                     i_valid,
    input  logic [SIZE_DATA_IN-1:0]  i_data,
    input  logic                     i_ready,
    output logic [SIZE_DATA_OUT-1:0] o_data,
    output logic                     o_valid,
    output logic                     o_done,
    output logic                     o_busy,
    output logic                     o_overflow
);

    localparam int N     = SIZE_DATA_OUT / SIZE_DATA_IN;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    typedef enum logic {
        IDLE,
        COLLECT
    } state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [SIZE_DATA_OUT-1:0] shreg_q, shreg_d;
    logic [SIZE_DATA_OUT-1:0] data_q, data_d;
    logic                     valid_q, valid_d;
    logic                     done_q, done_d;
    logic                     busy_q, busy_d;
    logic                     ovf_q, ovf_d;
    logic [SIZE_DATA_OUT-1:0] shifted;
    logic                     complete;

    // Shift register contents once the current symbol has been taken in
    always_comb begin
`ifdef SIPO_LSB_FIRST_EN
        shifted = (shreg_q >> SIZE_DATA_IN)
                | (SIZE_DATA_OUT'(i_data) << (SIZE_DATA_OUT - SIZE_DATA_IN));
`else
        shifted = (shreg_q << SIZE_DATA_IN) | SIZE_DATA_OUT'(i_data);
`endif
    end

    // Next-state, symbol collection and output-register handshake
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shreg_d  = shreg_q;
        data_d   = data_q;
        valid_d  = valid_q;
        done_d   = 1'b0;
        ovf_d    = ovf_q;
        complete = 1'b0;

        case (state_q)
            IDLE: begin
                // symbols in the entry cycle are deliberately not sampled
                if (i_start) begin
                    state_d = COLLECT;
                    cnt_d   = '0;
                    shreg_d = '0;
                end
            end
            COLLECT: begin
                if (!i_start) begin
                    // abort: partial word is thrown away silently
                    state_d = IDLE;
                    cnt_d   = '0;
                    shreg_d = '0;
                end else if (i_valid) begin
                    shreg_d = shifted;
                    if (cnt_q == CNT_LAST) begin
                        cnt_d    = '0;
                        complete = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                shreg_d = '0;
            end
        endcase

        // consumer takes the pending word
        if (valid_q && i_ready)
            valid_d = 1'b0;

        // a new word either lands (slot free or being freed) or is dropped
        if (complete) begin
            if (!valid_q || i_ready) begin
                data_d  = shifted;
                valid_d = 1'b1;
                done_d  = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end

        busy_d = (state_d == COLLECT);
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
        end
    end

    assign o_data     = data_q;
    assign o_valid    = valid_q;
    assign o_done     = done_q;
    assign o_busy     = busy_q;
    assign o_overflow = ovf_q;

endmodule

// File: tb/tb_sipo_symbol_collector.sv
// Directed bench for sipo_symbol_collector (default 2-bit symbols, 16-bit words).
module tb_sipo_symbol_collector;

    logic        i_clk, i_rst, i_start, i_valid, i_ready;
    logic [1:0]  i_data;
    logic [15:0] o_data;
    logic        o_valid, o_done, o_busy, o_overflow;

    int errors = 0;
    int checks = 0;
    int cyc_idx, done_cnt, last_done;

`ifdef SIPO_LSB_FIRST_EN
    localparam logic [15:0] EXP_1234 = 16'h1C84;
    localparam logic [15:0] EXP_5678 = 16'h2D95;
`else
    localparam logic [15:0] EXP_1234 = 16'h1234;
    localparam logic [15:0] EXP_5678 = 16'h5678;
`endif

    sipo_symbol_collector #(.SIZE_DATA_IN(2), .SIZE_DATA_OUT(16)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_valid(i_valid),
        .i_data(i_data), .i_ready(i_ready), .o_data(o_data), .o_valid(o_valid),
        .o_done(o_done), .o_busy(o_busy), .o_overflow(o_overflow)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // one clock: drive at negedge, observe at the following negedge
    task automatic cyc(input logic st, input logic vl, input logic [1:0] d);
        i_start = st; i_valid = vl; i_data = d;
        @(posedge i_clk);
        @(negedge i_clk);
        cyc_idx++;
        if (o_done) begin
            done_cnt++;
            last_done = cyc_idx;
        end
    endtask

    // 8 symbols of w, MSB pair first; optional idle gap after symbol gap_at
    task automatic send_word(input logic [15:0] w, input int gap_at, input int gap_len);
        logic [15:0] wv;
        wv = w;
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 1'b1, wv[15-2*i -: 2]);
            if (i + 1 == gap_at)
                for (int g = 0; g < gap_len; g++) cyc(1'b1, 1'b0, 2'b00);
        end
    endtask

    task automatic clr_cnt();
        cyc_idx = 0; done_cnt = 0; last_done = -1;
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_start = 0; i_valid = 0; i_data = 0; i_ready = 0;
        #2 i_rst = 1'b1;
        #2 i_rst = 1'b0;
        @(negedge i_clk);
    endtask

    task automatic test_reset();
        i_rst = 1'b1; i_start = 1; i_valid = 1; i_data = 2'b11; i_ready = 1;
        #1;
        checks++;
        if ({o_data, o_valid, o_done, o_busy, o_overflow} !== 20'h0) begin
            errors++;
            $display("FAIL reset_async: got data=%h v=%b d=%b b=%b o=%b want all 0",
                     o_data, o_valid, o_done, o_busy, o_overflow);
        end
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_held_idle: busy=%b want 0", o_busy);
        end
        i_rst = 1'b0; i_start = 0; i_valid = 0; i_ready = 0;
        @(negedge i_clk);
    endtask

    task automatic test_basic();
        do_reset();
        i_ready = 1;
        cyc(1'b1, 1'b0, 2'b00);
        checks++;
        if (o_busy !== 1'b1) begin
            errors++; $display("FAIL basic_busy: busy=%b want 1", o_busy);
        end
        clr_cnt();
        send_word(16'h1234, 0, 0);
        checks++;
        if (o_data !== EXP_1234 || o_valid !== 1'b1 || o_done !== 1'b1) begin
            errors++;
            $display("FAIL basic_word: data=%h v=%b d=%b want %h 1 1", o_data, o_valid, o_done, EXP_1234);
        end
        checks++;
        if (last_done !== 8 || done_cnt !== 1) begin
            errors++; $display("FAIL basic_latency: done at %0d cnt %0d want 8 1", last_done, done_cnt);
        end
        cyc(1'b1, 1'b0, 2'b00);
        checks++;
        if (o_valid !== 1'b0 || o_done !== 1'b0 || o_data !== EXP_1234) begin
            errors++;
            $display("FAIL basic_accept: v=%b d=%b data=%h want 0 0 %h", o_valid, o_done, o_data, EXP_1234);
        end
    endtask

    task automatic test_gap();
        do_reset();
        i_ready = 1;
        cyc(1'b1, 1'b0, 2'b00);
        clr_cnt();
        send_word(16'h1234, 4, 3);
        checks++;
        if (o_data !== EXP_1234 || done_cnt !== 1) begin
            errors++; $display("FAIL gap_word: data=%h cnt=%0d want %h 1", o_data, done_cnt, EXP_1234);
        end
        checks++;
        if (last_done !== 11) begin
            errors++; $display("FAIL gap_latency: done at %0d want 11", last_done);
        end
    endtask

    task automatic test_abort();
        logic [15:0] w;
        do_reset();
        i_ready = 1;
        w = 16'h1234;
        cyc(1'b1, 1'b0, 2'b00);
        clr_cnt();
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, w[15-2*i -: 2]);
        cyc(1'b0, 1'b1, 2'b11);
        checks++;
        if (o_busy !== 1'b0 || o_valid !== 1'b0 || done_cnt !== 0) begin
            errors++;
            $display("FAIL abort_idle: busy=%b v=%b cnt=%0d want 0 0 0", o_busy, o_valid, done_cnt);
        end
        cyc(1'b1, 1'b1, 2'b10);
        clr_cnt();
        send_word(16'h5678, 0, 0);
        checks++;
        if (o_data !== EXP_5678 || done_cnt !== 1 || last_done !== 8) begin
            errors++;
            $display("FAIL abort_word: data=%h cnt=%0d at %0d want %h 1 8", o_data, done_cnt, last_done, EXP_5678);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        i_ready = 0;
        cyc(1'b1, 1'b0, 2'b00);
        clr_cnt();
        send_word(16'h1234, 0, 0);
        send_word(16'h5678, 0, 0);
        checks++;
        if (o_data !== EXP_1234 || o_valid !== 1'b1 || o_overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_hold: data=%h v=%b ovf=%b want %h 1 1", o_data, o_valid, o_overflow, EXP_1234);
        end
        checks++;
        if (done_cnt !== 1 || o_done !== 1'b0) begin
            errors++; $display("FAIL ovf_done: cnt=%0d done=%b want 1 0", done_cnt, o_done);
        end
        i_ready = 1;
        cyc(1'b1, 1'b0, 2'b00);
        checks++;
        if (o_valid !== 1'b0 || o_overflow !== 1'b1 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL ovf_accept: v=%b ovf=%b busy=%b want 0 1 1", o_valid, o_overflow, o_busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] w;
        do_reset();
        i_ready = 0;
        w = 16'h5678;
        cyc(1'b1, 1'b0, 2'b00);
        clr_cnt();
        send_word(16'h1234, 0, 0);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) i_ready = 1;
            cyc(1'b1, 1'b1, w[15-2*i -: 2]);
        end
        checks++;
        if (o_data !== EXP_5678 || o_valid !== 1'b1 || o_done !== 1'b1 || o_overflow !== 1'b0) begin
            errors++;
            $display("FAIL b2b_swap: data=%h v=%b d=%b ovf=%b want %h 1 1 0",
                     o_data, o_valid, o_done, o_overflow, EXP_5678);
        end
        checks++;
        if (done_cnt !== 2 || last_done !== 16) begin
            errors++; $display("FAIL b2b_count: cnt=%0d at %0d want 2 16", done_cnt, last_done);
        end
    endtask

    task automatic test_mid_reset();
        logic [15:0] w;
        do_reset();
        i_ready = 0;
        w = 16'h1234;
        cyc(1'b1, 1'b0, 2'b00);
        send_word(16'h5678, 0, 0);
        send_word(16'h5678, 0, 0);
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, w[15-2*i -: 2]);
        #2 i_rst = 1'b1;
        #1;
        checks++;
        if ({o_data, o_valid, o_done, o_busy, o_overflow} !== 20'h0) begin
            errors++;
            $display("FAIL midrst_clear: data=%h v=%b d=%b b=%b o=%b want all 0",
                     o_data, o_valid, o_done, o_busy, o_overflow);
        end
        #1 i_rst = 1'b0;
        i_ready = 1;
        cyc(1'b1, 1'b0, 2'b00);
        checks++;
        if (o_busy !== 1'b1) begin
            errors++; $display("FAIL midrst_restart: busy=%b want 1", o_busy);
        end
        clr_cnt();
        send_word(16'h1234, 0, 0);
        checks++;
        if (o_data !== EXP_1234 || done_cnt !== 1 || last_done !== 8 || o_overflow !== 1'b0) begin
            errors++;
            $display("FAIL midrst_word: data=%h cnt=%0d at %0d ovf=%b want %h 1 8 0",
                     o_data, done_cnt, last_done, o_overflow, EXP_1234);
        end
    endtask

    initial begin
        i_start = 0; i_valid = 0; i_data = 0; i_ready = 0; i_rst = 0;
        clr_cnt();
        test_reset();
        test_basic();
        test_gap();
        test_abort();
        test_overflow();
        test_back_to_back();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, want finish before 200000");
        $fatal(1);
    end

endmodule

// File: doc/sipo_symbol_collector.md
SIPO_SYMBOL_COLLECTOR -- requirements
Module: sipo_symbol_collector

Interface
REQ-001 Parameter SIZE_DATA_IN, default 2, shall be the symbol width in bits.
REQ-002 Parameter SIZE_DATA_OUT, default 16, shall be the word width; it shall be an integer multiple of SIZE_DATA_IN, so N = SIZE_DATA_OUT/SIZE_DATA_IN symbols per word (default 8).
REQ-003 Port i_clk, input, 1 bit, shall be the single clock; all state updates on its rising edge.
REQ-004 Port i_rst, input, 1 bit, shall be the reset: asynchronous, active-high.
REQ-005 Port i_start, input, 1 bit, shall be the frame enable: high = collect, low = abort/idle.
REQ-006 Port i_valid, input, 1 bit, shall qualify i_data as one symbol.
REQ-007 Port i_data, input, SIZE_DATA_IN bits, shall be the serial symbol.
REQ-008 Port i_ready, input, 1 bit, shall be the downstream word acceptance.
REQ-009 Port o_data, output, SIZE_DATA_OUT bits, shall be the assembled word.
REQ-010 Port o_valid, output, 1 bit, shall flag o_data holding an unaccepted word.
REQ-011 Port o_done, output, 1 bit, shall pulse for one cycle per completed word.
REQ-012 Port o_busy, output, 1 bit, shall be high while in COLLECT.
REQ-013 Port o_overflow, output, 1 bit, shall be a sticky word-drop flag.

Function
REQ-014 FSM states IDLE and COLLECT shall be the only states; all outputs shall be registered.
REQ-015 IDLE with i_start=1 shall go to COLLECT with symbol count 0; symbols presented in that cycle shall be ignored.
REQ-016 COLLECT with i_start=1 and i_valid=1 shall shift i_data into the shift register and increment the count (0..N-1).
REQ-017 COLLECT with i_valid=0 shall hold the shift register and count.
REQ-018 COLLECT with i_start=0 shall discard the partial word, clear the count and go to IDLE; o_done shall not pulse.
REQ-019 The accepted symbol at count N-1 shall complete the word; the output register, o_valid and the o_done pulse shall be visible in the cycle after that edge (1-cycle latency).
REQ-020 On completion the count shall wrap to 0; the FSM shall stay in COLLECT if i_start=1 (back-to-back words, no bubble), else go to IDLE.
REQ-021 o_valid shall stay high, with o_data stable, until sampled with i_ready=1; it then clears unless a new word completes in the same cycle.
REQ-022 A completion with o_valid=1 and i_ready=1 in the same cycle shall load the new word, keep o_valid high and pulse o_done.
REQ-023 A completion with o_valid=1 and i_ready=0 shall drop the new word, leave o_data unchanged, set o_overflow and not pulse o_done.
REQ-024 o_overflow shall remain set until reset.
REQ-025 The output register shall be separate from the shift register, so collection continues while o_valid waits.

Reset
REQ-026 Asserting i_rst shall, without a clock, force IDLE, count 0, shift register 0, o_data=0, o_valid=0, o_done=0, o_busy=0 and o_overflow=0.
REQ-027 Reset mid-word shall discard the partial word and any pending output word.
REQ-028 The first state change after release shall occur on the first rising i_clk with i_rst=0.

Configuration
REQ-029 Macro SIPO_LSB_FIRST_EN undefined: the first symbol of a word shall land in o_data[SIZE_DATA_OUT-1 -: SIZE_DATA_IN] (MSB-first, matching the PISO transmit order).
REQ-030 Macro SIPO_LSB_FIRST_EN defined: the first symbol shall land in o_data[SIZE_DATA_IN-1:0] (LSB-first); all other behaviour shall be identical.

Verification
REQ-031 Reset, i_start=1, then 8 valid symbols 00,01,00,10,00,11,01,00 with i_ready=1 -> one o_done pulse, o_data=0x1234 one cycle after the 8th symbol; with SIPO_LSB_FIRST_EN -> 0x1C84.
REQ-032 The same stream with i_valid low for 3 cycles after symbol 4 -> o_data=0x1234, o_done delayed by exactly 3 cycles.
REQ-033 i_start dropped after 5 symbols, then reasserted with 8 symbols encoding 0x5678 -> single word 0x5678, no partial word emitted.
REQ-034 Two back-to-back words 0x1234 and 0x5678 with i_ready=0 -> o_data holds 0x1234, o_overflow=1, one o_done pulse; then i_ready=1 -> o_valid clears.
REQ-035 i_rst pulsed between clock edges after symbol 6 -> all outputs 0 immediately; the next full 8-symbol frame decodes correctly.
